dmem_byte_responder: RTL
========================

# dmem_byte_responder

Data-memory responder for the MEM stage of the pipelined MIPS core. It answers the load/store requests issued by the MEM stage: aligned byte, halfword and word accesses with byte-lane write merging and sign/zero-extended load data. Load data is registered directly into the write-back stage, so this block owns the W-stage copy of memory read data. Optional wait states stall the pipeline through a small counter FSM.

## Interface
Parameters:
- `WIDTH_32`, 32: data and address width (fixed at 32).
- `DEPTH_WORDS`, 256: memory depth in 32-bit words; power of two.
- `WAIT_CYCLES`, 2: extra cycles per aligned access when `DMEM_WAIT_STATES_EN` is defined; legal range 0..15.

Ports:
- `clk`  in  1  clock, rising-edge.
- `rst_n`  in  1  reset; one clock; asynchronous, active-low.
- `EN`  in  1  pipeline advance; W-stage outputs and memory writes commit only when high.
- `MemRead_M`  in  1  load request.
- `MemWrite_M`  in  1  store request; wins over `MemRead_M` if both are high.
- `ByteControl_M`  in  4  access-size and extension control:
  - [1:0] size: 00 byte, 01 half, 10 word, 11 word.
  - [2] zero-extend load.
  - [3] ignored.
- `ALU_result_M`  in  32  byte address.
- `WriteData_M`  in  32  store data, right-justified.
- `ReadData_W`  out  32  extended load result.
- `MisalignErr_W`  out  1  misaligned access flag, W-stage.
- `Stall_M`  out  1  combinational; hold the MEM stage and everything upstream.

## Operation
- Word index is `ALU_result_M[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so accesses wrap modulo the depth.
- Byte order is little-endian.
  - Byte lane = addr[1:0].
  - Half lane = addr[1].
- Misaligned access:
  - Conditions: half with addr[0]=1, or word/11 with addr[1:0]≠0.
  - The write is suppressed and load data is 0.
  - The access never stalls.
- Store:
  - Byte: `WriteData_M[7:0]` goes to the selected lane.
  - Half: `WriteData_M[15:0]` goes to the selected half.
  - Word: all lanes are written.
  - Unselected bytes are preserved.
- Load: the selected byte or half is sign-extended, or zero-extended when [2]=1. A word is passed unchanged.
- FSM states:
  - IDLE → WAIT on an aligned access when WAIT_CYCLES>0; the counter loads WAIT_CYCLES−1.
  - WAIT: the counter decrements each cycle while nonzero.
  - WAIT with counter=0 and EN=1 → IDLE (commit).
  - WAIT with counter=0 and EN=0: stay in WAIT.
- Commit point: the rising edge where `Stall_M`=0 and `EN`=1, in IDLE (no-wait or misaligned access) or in WAIT with counter=0.
- On commit:
  - The store is written once.
  - `ReadData_W` <= the load result, or 0 for a store or for no access.
  - `MisalignErr_W` <= the misaligned flag.
- EN=1 with no access: `ReadData_W` <= 0 and `MisalignErr_W` <= 0.
- EN=0: both W outputs hold their values and no write occurs.
- `Stall_M` = (IDLE & aligned access & WAIT_CYCLES>0) | (WAIT & counter≠0).
- While `Stall_M`=1, request inputs must stay stable. Changing them during a stall is a protocol violation and the resulting data is undefined.

## Timing
- Reset values: `ReadData_W`=0, `MisalignErr_W`=0, state IDLE, counter 0, so `Stall_M`=0. Memory contents are not reset.
- Reset asserted mid-access: the FSM returns to IDLE immediately and the pending store is dropped.
- Latency:
  - With no wait states, load data appears in `ReadData_W` one edge after the request cycle.
  - With wait states, it appears after WAIT_CYCLES+1 edges.
- `Stall_M` is high for exactly WAIT_CYCLES cycles per aligned access when EN stays 1.
- Back-to-back accesses: the next access may be presented in the cycle right after the commit; there is no idle cycle.

## Configuration
- Macro: `DMEM_WAIT_STATES_EN`.
- Defined: the WAIT state, the counter and `Stall_M` behave as described above.
- Undefined:
  - `WAIT_CYCLES` is ignored and the FSM and counter are removed.
  - `Stall_M` is tied to 0.
  - Every access commits on the edge of its request cycle when EN=1.

## Test plan
- Store word 0xDEADBEEF at 0x10, then load word at 0x10 → `ReadData_W`=0xDEADBEEF. With `DMEM_WAIT_STATES_EN` and WAIT_CYCLES=2, `Stall_M` is high for 2 cycles and data arrives 3 edges after the request.
- Store byte 0x80 at 0x13 over 0x11223344 → word reads 0x80223344. lb at 0x13 returns 0xFFFFFF80; lbu at 0x13 returns 0x00000080.
- Store half 0xABCD at 0x22 over 0 → word reads 0xABCD0000. lh at 0x22 returns 0xFFFFABCD.
- Misaligned cases:
  - lw at 0x21 → `MisalignErr_W`=1, `ReadData_W`=0, no stall.
  - sh at 0x23 → the memory word is unchanged.
- EN=0 held for 3 cycles while WAIT reaches counter 0 → state stays WAIT, `Stall_M`=0, outputs hold, a single write occurs once EN=1.
- `rst_n` pulsed low during WAIT of a store → outputs return to 0, `Stall_M`=0, the target word is unchanged.

Source files
------------

// File: rtl/dmem_byte_responder.sv
// MIPS MEM-stage data memory: byte/half/word access, lane merging, load extension, W-stage registers.
// Optional wait states (macro DMEM_WAIT_STATES_EN) stall the pipeline through a small counter FSM.
module dmem_byte_responder #(
  parameter int WIDTH_32    = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                EN,
  input  logic                MemRead_M,
  input  logic                MemWrite_M,
  input  logic [3:0]          ByteControl_M,
  input  logic [WIDTH_32-1:0] ALU_result_M,
  input  logic [WIDTH_32-1:0] WriteData_M,
  output logic [WIDTH_32-1:0] ReadData_W,
  output logic                MisalignErr_W,
  output logic                Stall_M
);
  localparam int AW = $clog2(DEPTH_WORDS);

  logic [WIDTH_32-1:0] mem [DEPTH_WORDS];

  logic [AW-1:0]       idx;
  logic [1:0]          size;
  logic [1:0]          lane;
  logic                access;
  logic                misalign;
  logic                stall;
  logic                commit;
  logic [WIDTH_32-1:0] rd_word;
  logic [WIDTH_32-1:0] ld_data;
  logic [WIDTH_32-1:0] wr_word;
  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;
  logic                unused_bits;

  assign idx      = ALU_result_M[AW+1:2];
  assign size     = ByteControl_M[1:0];
  assign lane     = ALU_result_M[1:0];
  assign access   = MemRead_M | MemWrite_M;
  assign misalign = access & (((size == 2'b01) & lane[0]) | (size[1] & (lane != 2'b00)));
  assign rd_word  = mem[idx];
  assign unused_bits = ^{ByteControl_M[3], ALU_result_M[WIDTH_32-1:AW+2]};

  always_comb begin
    byte_sel = rd_word[{lane, 3'b000} +: 8];
    half_sel = rd_word[{lane[1], 4'b0000} +: 16];
    ld_data  = '0;
    if (!misalign) begin
      case (size)
        2'b00:   ld_data = ByteControl_M[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        2'b01:   ld_data = ByteControl_M[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
        default: ld_data = rd_word;
      endcase
    end
  end

  // Read-modify-write merge: only the addressed lanes take new store data.
  always_comb begin
    wr_word = rd_word;
    case (size)
      2'b00:   wr_word[{lane, 3'b000} +: 8]     = WriteData_M[7:0];
      2'b01:   wr_word[{lane[1], 4'b0000} +: 16] = WriteData_M[15:0];
      default: wr_word = WriteData_M;
    endcase
  end

`ifdef DMEM_WAIT_STATES_EN
  typedef enum logic {IDLE, WAIT} state_t;
  localparam bit       HAS_WAIT = (WAIT_CYCLES > 0);
  localparam logic [3:0] WLOAD  = 4'(WAIT_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The countdown runs regardless of EN; only the exit from WAIT waits for EN.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (access && !misalign && HAS_WAIT) begin
          stall     = 1'b1;
          state_nxt = WAIT;
          cnt_nxt   = WLOAD;
        end
      end
      WAIT: begin
        if (cnt != 4'd0) begin
          stall   = 1'b1;
          cnt_nxt = cnt - 4'd1;
        end else if (EN) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
`else
  assign stall = 1'b0;
`endif

  assign Stall_M = stall;
  assign commit  = EN & ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ReadData_W    <= '0;
      MisalignErr_W <= 1'b0;
    end else if (commit) begin
      ReadData_W    <= (MemRead_M && !MemWrite_M) ? ld_data : '0;
      MisalignErr_W <= misalign;
    end
  end

  always_ff @(posedge clk) begin
    if (commit && MemWrite_M && !misalign) begin
      mem[idx] <= wr_word;
    end
  end
endmodule
